// File: rtl/microcode_rom_pkg.sv
// Shared control-unit constants: microaddress names, fixed control words and
// the field layout of a 36-bit control word.
package microcode_rom_pkg;

   localparam int ADDR_W = 5;
   localparam int WORD_W = 36;
   localparam int DEPTH  = 32;

   // next-microaddress field occupies the low bits of each word
   localparam int NA_MSB = 4;
   localparam int NA_LSB = 0;

   localparam logic [ADDR_W-1:0] FETCH1  = 5'd0;
   localparam logic [ADDR_W-1:0] JMPNZY1 = 5'd9;
   localparam logic [ADDR_W-1:0] JMPNZN1 = 5'd11;
   localparam logic [ADDR_W-1:0] MUL1    = 5'd18;
   localparam logic [ADDR_W-1:0] LOAD2   = 5'd20;
   localparam logic [ADDR_W-1:0] STORE3  = 5'd23;

   localparam logic [WORD_W-1:0] W_FETCH1  = 36'h0A0000001;
   localparam logic [WORD_W-1:0] W_JMPNZY1 = 36'h0A000000A;
   localparam logic [WORD_W-1:0] W_JMPNZN1 = 36'h000000100;
   localparam logic [WORD_W-1:0] W_MUL1    = 36'h060074C00;
   localparam logic [WORD_W-1:0] W_LOAD2   = 36'h210000000;
   localparam logic [WORD_W-1:0] W_STORE3  = 36'h100000000;
   localparam logic [WORD_W-1:0] W_NOP     = '0;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [WORD_W-1:0] word);
      return word[NA_MSB:NA_LSB];
   endfunction

endpackage

// File: rtl/microcode_rom.sv
// Microsequencer control store: 32 x 36-bit fixed table with a registered
// output so the control word holds steady for a whole cycle.
module microcode_rom
   import microcode_rom_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   output logic [WORD_W-1:0] out
);

   logic [WORD_W-1:0] w_word;
   logic [WORD_W-1:0] r_out;

   // unlisted addresses decode to the all-zero no-op word
   always_comb begin
      w_word = W_NOP;
      case (addr)
         FETCH1:  w_word = W_FETCH1;
         JMPNZY1: w_word = W_JMPNZY1;
         JMPNZN1: w_word = W_JMPNZN1;
         MUL1:    w_word = W_MUL1;
         LOAD2:   w_word = W_LOAD2;
         STORE3:  w_word = W_STORE3;
         default: w_word = W_NOP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_out <= '0;
      else     r_out <= w_word;
   end

   assign out = r_out;

endmodule

// File: tb/tb_microcode_rom.sv
// Self-checking bench for microcode_rom: directed steps plus random addresses
// against a bit-list reference table, with async reset pulses mixed in.
module tb_microcode_rom;

   logic        clk;
   logic        rst;
   logic [4:0]  addr;
   logic [35:0] out;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [35:0] model [32];

   microcode_rom dut (
      .clk  (clk),
      .rst  (rst),
      .addr (addr),
      .out  (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // drive addr away from the edge, sample just after the capturing edge
   task automatic step(input logic [4:0] a, input string tag);
      @(negedge clk);
      addr = a;
      @(posedge clk);
      #1;
      check(tag, out, model[a]);
   endtask

   task automatic async_reset_pulse(input string tag);
      #1 rst = 1'b1;
      #1 check(tag, out, 36'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // reference table built from the set-bit lists of each defined entry
      for (int i = 0; i < 32; i++) model[i] = '0;
      model[0][31]  = 1'b1; model[0][29]  = 1'b1; model[0][0]  = 1'b1;
      model[9][31]  = 1'b1; model[9][29]  = 1'b1; model[9][3]  = 1'b1; model[9][1] = 1'b1;
      model[11][8]  = 1'b1;
      model[18][30] = 1'b1; model[18][29] = 1'b1; model[18][18] = 1'b1; model[18][17] = 1'b1;
      model[18][16] = 1'b1; model[18][14] = 1'b1; model[18][11] = 1'b1; model[18][10] = 1'b1;
      model[20][33] = 1'b1; model[20][28] = 1'b1;
      model[23][32] = 1'b1;

      rst  = 1'b1;
      addr = 5'd0;
      repeat (3) @(posedge clk);
      #1 check("reset_hold", out, 36'h0);

      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 check("first_after_reset", out, 36'h0A0000001);

      async_reset_pulse("async_reset_clear");

      // defined entries back to back, literal expected words
      step(5'd0,  "seq_fetch1");  check("lit_fetch1",  out, 36'h0A0000001);
      step(5'd9,  "seq_jmpnzy1"); check("lit_jmpnzy1", out, 36'h0A000000A);
      step(5'd11, "seq_jmpnzn1"); check("lit_jmpnzn1", out, 36'h000000100);
      step(5'd20, "seq_load2");   check("lit_load2",   out, 36'h210000000);
      step(5'd23, "seq_store3");  check("lit_store3",  out, 36'h100000000);
      step(5'd18, "seq_mul1");    check("lit_mul1",    out, 36'h060074C00);

      step(5'd29, "undef_29"); check("zero_29", out, 36'h0);
      step(5'd30, "undef_30"); check("zero_30", out, 36'h0);
      step(5'd31, "undef_31"); check("zero_31", out, 36'h0);
      step(5'd5,  "undef_5");  check("zero_5",  out, 36'h0);

      // address change between edges must not reach out early
      step(5'd0, "midcyc_pre");
      @(negedge clk);
      addr = 5'd9;
      #1 check("midcyc_hold", out, 36'h0A0000001);
      @(posedge clk);
      #1 check("midcyc_update", out, 36'h0A000000A);

      step(5'd0,  "na_fetch1_w");  check("na_fetch1",  {31'd0, out[4:0]}, 36'd1);
      step(5'd9,  "na_jmpnzy1_w"); check("na_jmpnzy1", {31'd0, out[4:0]}, 36'd10);
      step(5'd18, "na_mul1_w");    check("na_mul1",    {31'd0, out[4:0]}, 36'd0);

      for (int a = 0; a < 32; a++) begin
         step(a[4:0], $sformatf("sweep_%0d", a));
         check($sformatf("noxz_%0d", a), {35'd0, $isunknown(out)}, 36'd0);
      end

      // reset mid-sequence, then the first edge reloads the current address
      step(5'd20, "pre_midreset");
      async_reset_pulse("midseq_reset");
      @(posedge clk);
      #1 check("post_midreset", out, model[20]);

      for (int k = 0; k < 300; k++) begin
         logic [4:0] ra;
         ra = 5'($urandom_range(0, 31));
         step(ra, $sformatf("rand_%0d_a%0d", k, ra));
         if ($urandom_range(0, 19) == 0) async_reset_pulse($sformatf("rand_rst_%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
